// File: rtl/alu_ex_if.sv
// Handshake bundle between the ALU decoder, the execute stage and the MEM/writeback stage.
// The master view is the surrounding pipeline; the slave view is the execute stage.
interface alu_ex_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_aluop;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [RD_W-1:0]  in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_illegal;
    logic [RD_W-1:0]  out_rd;

    modport master (
        output in_valid, in_aluop, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_illegal, out_rd
    );

    modport slave (
        input  in_valid, in_aluop, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_illegal, out_rd
    );
endinterface

// File: rtl/alu_ex_stage.sv
// Execute stage: computes the ALU result at accept and buffers it in a 2-entry queue.
// All outputs, including in_ready, are registered copies of the next queue state.
module alu_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    alu_ex_if.slave    bus
);
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_ORI  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;

    logic [WIDTH-1:0] res_mem_r [2];
    logic             ill_mem_r [2];
    logic [RD_W-1:0]  rd_mem_r  [2];
    logic [WIDTH-1:0] res_mem_s [2];
    logic             ill_mem_s [2];
    logic [RD_W-1:0]  rd_mem_s  [2];
    logic [1:0]       count_r, count_s;
    logic             wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic             in_ready_r, out_valid_r, out_zero_r, out_illegal_r;
    logic [WIDTH-1:0] out_result_r;
    logic [RD_W-1:0]  out_rd_r;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ill_s;
    logic             accept_s, pop_s;
    logic [4:0]       shamt_s;

    assign shamt_s  = bus.in_a[4:0];
    assign accept_s = bus.in_valid & in_ready_r;
    assign pop_s    = out_valid_r & bus.out_ready;

    // ALU datapath for the op being offered upstream
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_ill_s = 1'b0;
        case (bus.in_aluop)
            ALU_ADDU: alu_res_s = bus.in_a + bus.in_b;
            ALU_SUBU: alu_res_s = bus.in_a - bus.in_b;
            ALU_AND:  alu_res_s = bus.in_a & bus.in_b;
            ALU_OR:   alu_res_s = bus.in_a | bus.in_b;
            ALU_XOR:  alu_res_s = bus.in_a ^ bus.in_b;
            ALU_NOR:  alu_res_s = ~(bus.in_a | bus.in_b);
            ALU_ORI:  alu_res_s = bus.in_a | {16'h0000, bus.in_b[15:0]};
            ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
            ALU_LUI:  alu_res_s = {bus.in_b[15:0], 16'h0000};
            ALU_SLL:  alu_res_s = bus.in_b << shamt_s;
            ALU_SRL:  alu_res_s = bus.in_b >> shamt_s;
            ALU_SRA:  alu_res_s = $signed(bus.in_b) >>> shamt_s;
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_ill_s = 1'b1;
            end
        endcase
    end

    // Next queue state; flush drops both the queued entries and any concurrent accept/pop
    always_comb begin
        res_mem_s = res_mem_r;
        ill_mem_s = ill_mem_r;
        rd_mem_s  = rd_mem_r;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        count_s   = count_r;
        if (flush) begin
            wr_ptr_s = 1'b0;
            rd_ptr_s = 1'b0;
            count_s  = 2'd0;
        end else begin
            if (accept_s) begin
                res_mem_s[wr_ptr_r] = alu_res_s;
                ill_mem_s[wr_ptr_r] = alu_ill_s;
                rd_mem_s[wr_ptr_r]  = bus.in_rd;
                wr_ptr_s            = ~wr_ptr_r;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = ~rd_ptr_r;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_s = count_r + 2'd1;
                2'b01:   count_s = count_r - 2'd1;
                default: count_s = count_r;
            endcase
        end
    end

    // State and registered head/ready outputs; reset outranks flush
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                res_mem_r[i] <= {WIDTH{1'b0}};
                ill_mem_r[i] <= 1'b0;
                rd_mem_r[i]  <= {RD_W{1'b0}};
            end
            count_r       <= 2'd0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_result_r  <= {WIDTH{1'b0}};
            out_zero_r    <= 1'b0;
            out_illegal_r <= 1'b0;
            out_rd_r      <= {RD_W{1'b0}};
        end else begin
            res_mem_r   <= res_mem_s;
            ill_mem_r   <= ill_mem_s;
            rd_mem_r    <= rd_mem_s;
            count_r     <= count_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            in_ready_r  <= (count_s != 2'd2);
            out_valid_r <= (count_s != 2'd0);
            if (count_s != 2'd0) begin
                out_result_r  <= res_mem_s[rd_ptr_s];
                out_zero_r    <= (res_mem_s[rd_ptr_s] == {WIDTH{1'b0}});
                out_illegal_r <= ill_mem_s[rd_ptr_s];
                out_rd_r      <= rd_mem_s[rd_ptr_s];
            end else begin
                out_result_r  <= {WIDTH{1'b0}};
                out_zero_r    <= 1'b0;
                out_illegal_r <= 1'b0;
                out_rd_r      <= {RD_W{1'b0}};
            end
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_zero    = out_zero_r;
    assign bus.out_illegal = out_illegal_r;
    assign bus.out_rd      = out_rd_r;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: per-op results, queue fill/drain order, flush and reset.
module tb_alu_ex_stage;
    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_ORI  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_LUI  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;
    localparam logic [3:0] OP_XXX  = 4'd15;

    logic clk;
    logic reset;
    logic flush;
    int   checks_r;
    int   errors_r;

    alu_ex_if #(.WIDTH(32), .RD_W(5)) bus ();

    alu_ex_stage #(.WIDTH(32), .RD_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            errors_r++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_aluop = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"},  {31'd0, bus.out_valid},   32'd0);
        check({tag, "_ready"},  {31'd0, bus.in_ready},    32'd1);
        check({tag, "_result"}, bus.out_result,           32'd0);
        check({tag, "_zero"},   {31'd0, bus.out_zero},    32'd0);
        check({tag, "_ill"},    {31'd0, bus.out_illegal}, 32'd0);
        check({tag, "_rd"},     {27'd0, bus.out_rd},      32'd0);
    endtask

    // Fill queue with two ops while stalled, offer a third, then hit it with flush or reset
    task automatic fill_and_kill(input bit use_reset, input string tag);
        bus.out_ready = 1'b0;
        drive(OP_ADDU, 32'd10, 32'd1, 5'd1);
        step();
        drive(OP_ADDU, 32'd20, 32'd2, 5'd2);
        step();
        check({tag, "_full_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_full_head"},  bus.out_result,        32'd11);
        drive(OP_ADDU, 32'd30, 32'd3, 5'd3);
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check_empty({tag, "_after"});
        step();
        check({tag, "_dropped"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    initial begin
        checks_r = 0;
        errors_r = 0;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_aluop  = 4'd0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_rd     = 5'd0;
        bus.out_ready = 1'b1;

        vecs[0]  = '{OP_ADDU, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{OP_SUBU, 32'd3,          32'd3,          32'd0,          1'b0};
        vecs[2]  = '{OP_XXX,  32'd9,          32'd4,          32'd0,          1'b1};
        vecs[3]  = '{OP_SRA,  32'd4,          32'h8000_0000,  32'hF800_0000,  1'b0};
        vecs[4]  = '{OP_SRL,  32'd4,          32'h8000_0000,  32'h0800_0000,  1'b0};
        vecs[5]  = '{OP_LUI,  32'd0,          32'h0000_1234,  32'h1234_0000,  1'b0};
        vecs[6]  = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
        vecs[7]  = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[8]  = '{OP_AND,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0};
        vecs[9]  = '{OP_OR,   32'hFF00_0000,  32'h0000_00FF,  32'hFF00_00FF,  1'b0};
        vecs[10] = '{OP_XOR,  32'hAAAA_AAAA,  32'hFFFF_0000,  32'h5555_AAAA,  1'b0};
        vecs[11] = '{OP_NOR,  32'hF0F0_F0F0,  32'h0000_FFFF,  32'h0F0F_0000,  1'b0};
        vecs[12] = '{OP_ORI,  32'hF000_0000,  32'hFFFF_1234,  32'hF000_1234,  1'b0};
        vecs[13] = '{OP_SLL,  32'd4,          32'd1,          32'd16,         1'b0};

        step();
        reset = 1'b0;
        check_empty("reset");

        // Back-to-back ops with out_ready=1: each new op replaces the head the same edge
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
            step();
            check($sformatf("op%0d_valid", i),  {31'd0, bus.out_valid},   32'd1);
            check($sformatf("op%0d_result", i), bus.out_result,           vecs[i].res);
            check($sformatf("op%0d_zero", i),   {31'd0, bus.out_zero},    {31'd0, vecs[i].res == 32'd0});
            check($sformatf("op%0d_ill", i),    {31'd0, bus.out_illegal}, {31'd0, vecs[i].ill});
            check($sformatf("op%0d_rd", i),     {27'd0, bus.out_rd},      i + 1);
        end
        bus.in_valid = 1'b0;
        step();
        check_empty("drained");

        // Backpressure: third op held until the first pop, then in order drain
        bus.out_ready = 1'b0;
        drive(OP_ADDU, 32'd1, 32'd1, 5'd1);
        step();
        check("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
        drive(OP_ADDU, 32'd2, 32'd2, 5'd2);
        step();
        check("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
        check("bp_head2",  bus.out_result,        32'd2);
        drive(OP_ADDU, 32'd3, 32'd3, 5'd3);
        step();
        check("bp_held_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_held_head",  bus.out_result,        32'd2);
        check("bp_held_rd",    {27'd0, bus.out_rd},   32'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp_pop1_ready", {31'd0, bus.in_ready}, 32'd1);
        check("bp_pop1_head",  bus.out_result,        32'd4);
        step();
        bus.in_valid = 1'b0;
        check("bp_pop2_head", bus.out_result,      32'd6);
        check("bp_pop2_rd",   {27'd0, bus.out_rd}, 32'd3);
        step();
        check_empty("bp_empty");

        fill_and_kill(1'b0, "flush");
        fill_and_kill(1'b1, "reset");

        // Stage still usable after the reset
        bus.out_ready = 1'b1;
        drive(OP_SUBU, 32'd10, 32'd3, 5'd7);
        step();
        bus.in_valid = 1'b0;
        check("post_result", bus.out_result,      32'd7);
        check("post_rd",     {27'd0, bus.out_rd}, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
        $finish;
    end
endmodule
